mem_req_arbiter: RTL and testbench

Request scheduler in front of the byte-serial memory controller. It arbitrates among three requesters: instruction fetch, LSU load and LSU store. It issues one transaction at a time to the controller and returns each completion to its owner. It also enforces store priority, a fetch anti-starvation rule, IO back-pressure on stores, and squashing of speculative (fetch/load) traffic on pipeline flush.

---
 rtl/mem_req_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Request scheduler for the byte-serial memory controller. It arbitrates fetch, load and
// store, keeps one transaction in flight, and squashes speculative traffic on flush.
module mem_req_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter logic [31:0] IO_ADDR      = 32'h30000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_in,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    output logic        ld_done,
    output logic [31:0] ld_data,
    input  logic        st_req,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_size,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        mc_valid,
    output logic        mc_we,
    output logic [31:0] mc_addr,
    output logic [1:0]  mc_size,
    output logic [31:0] mc_wdata,
    input  logic        mc_done,
    input  logic [31:0] mc_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
    typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } mc_req_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t      state, state_d;
    owner_t      owner, owner_d;
    logic        killed, killed_d;
    logic [3:0]  starve_cnt, starve_d;
    mc_req_t     req_q, req_d;
    logic        valid_d, if_done_d, ld_done_d, st_done_d;
    logic [31:0] if_data_d, ld_data_d, rdata_m;
    logic        st_elig, ld_elig, if_elig, fetch_grant, kill_now;

    assign mc_we    = req_q.we;
    assign mc_addr  = req_q.addr;
    assign mc_size  = req_q.size;
    assign mc_wdata = req_q.wdata;

    always_comb begin
        case (req_q.size)
            2'd0:    rdata_m = {24'h0, mc_rdata[7:0]};
            2'd1:    rdata_m = {16'h0, mc_rdata[15:0]};
            default: rdata_m = mc_rdata;
        endcase
    end

    always_comb begin
        state_d     = state;
        owner_d     = owner;
        killed_d    = killed;
        req_d       = req_q;
        valid_d     = 1'b0;
        if_done_d   = 1'b0;
        ld_done_d   = 1'b0;
        st_done_d   = 1'b0;
        if_data_d   = if_data;
        ld_data_d   = ld_data;
        fetch_grant = 1'b0;
        st_elig     = st_req && !(st_addr == IO_ADDR && io_buffer_full);
        ld_elig     = ld_req && !flush_in;
        if_elig     = if_req && !flush_in;
        // A committed store is never squashed; fetch/load die on flush.
        kill_now    = killed || (flush_in && owner != OWN_STORE);

        case (state)
            IDLE: begin
                killed_d = 1'b0;
                if (if_elig && starve_cnt >= STARVE_LIM) begin
                    fetch_grant = 1'b1;
                end else if (st_elig) begin
                    owner_d = OWN_STORE;
                    req_d   = '{we: 1'b1, addr: st_addr, size: st_size, wdata: st_data};
                    valid_d = 1'b1;
                    state_d = WAIT;
                end else if (ld_elig) begin
                    owner_d = OWN_LOAD;
                    req_d   = '{we: 1'b0, addr: ld_addr, size: ld_size, wdata: 32'h0};
                    valid_d = 1'b1;
                    state_d = WAIT;
                end else if (if_elig) begin
                    fetch_grant = 1'b1;
                end
                if (fetch_grant) begin
                    owner_d = OWN_FETCH;
                    req_d   = '{we: 1'b0, addr: if_addr, size: 2'd2, wdata: 32'h0};
                    valid_d = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT, DRAIN: begin
                if (mc_done) begin
                    state_d  = IDLE;
                    killed_d = 1'b0;
                    if (!kill_now) begin
                        case (owner)
                            OWN_FETCH: begin if_done_d = 1'b1; if_data_d = rdata_m; end
                            OWN_LOAD:  begin ld_done_d = 1'b1; ld_data_d = rdata_m; end
                            default:   st_done_d = 1'b1;
                        endcase
                    end
                end else if (kill_now) begin
                    killed_d = 1'b1;
                    state_d  = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req || flush_in || fetch_grant)
            starve_d = 4'd0;
        else if (starve_cnt != 4'hF)
            starve_d = starve_cnt + 4'd1;
        else
            starve_d = starve_cnt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            owner      <= OWN_FETCH;
            killed     <= 1'b0;
            starve_cnt <= 4'd0;
            req_q      <= '0;
            mc_valid   <= 1'b0;
            if_done    <= 1'b0;
            ld_done    <= 1'b0;
            st_done    <= 1'b0;
            if_data    <= 32'h0;
            ld_data    <= 32'h0;
        end else if (rdy_in) begin
            state      <= state_d;
            owner      <= owner_d;
            killed     <= killed_d;
            starve_cnt <= starve_d;
            req_q      <= req_d;
            mc_valid   <= valid_d;
            if_done    <= if_done_d;
            ld_done    <= ld_done_d;
            st_done    <= st_done_d;
            if_data    <= if_data_d;
            ld_data    <= ld_data_d;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: tasks drive requesters and a controller model,
// completions are popped and compared by a negedge monitor.
module tb_mem_req_arbiter;
    localparam int FE = 0, LD = 1, ST = 2;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        rst_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0, io_buffer_full = 1'b0;
    logic        if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0, mc_done = 1'b0;
    logic [31:0] if_addr = '0, ld_addr = '0, st_addr = '0, st_data = '0, mc_rdata = '0;
    logic [1:0]  ld_size = '0, st_size = '0;
    logic        if_done, ld_done, st_done, mc_valid, mc_we;
    logic [31:0] if_data, ld_data, mc_addr, mc_wdata;
    logic [1:0]  mc_size;

    int checks = 0, errors = 0;

    typedef struct {
        int          owner;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_req_arbiter #(.STARVE_LIMIT(8), .IO_ADDR(32'h30000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
        .mc_valid(mc_valid), .mc_we(mc_we), .mc_addr(mc_addr), .mc_size(mc_size),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata)
    );

    // Completion monitor: every done pulse must match the head of the scoreboard.
    exp_t        mon_e;
    logic [2:0]  mon_got, mon_exp;
    logic [31:0] mon_dat;
    always @(negedge clk_in) begin
        if (if_done || ld_done || st_done) begin
            checks++;
            mon_got = {st_done, ld_done, if_done};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got {st,ld,if}=%b, required no completion", mon_got);
            end else begin
                mon_e   = sb.pop_front();
                mon_exp = 3'b001 << mon_e.owner;
                mon_dat = (mon_e.owner == FE) ? if_data : (mon_e.owner == LD) ? ld_data : 32'h0;
                if (mon_got !== mon_exp || mon_dat !== mon_e.data) begin
                    errors++;
                    $display("FAIL completion: got done=%b data=%h, required done=%b data=%h",
                             mon_got, mon_dat, mon_exp, mon_e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input int o, input logic [31:0] d);
        exp_t e;
        e.owner = o;
        e.data  = d;
        sb.push_back(e);
    endtask

    // Waits (bounded) for mc_valid; w is the number of edges it took.
    task automatic wait_issue(output int w);
        w = 0;
        while (mc_valid !== 1'b1 && w < 30) begin
            tick();
            w++;
        end
    endtask

    // Controller model: completes lat cycles later with rdata.
    task automatic complete(input logic [31:0] rdata, input int lat);
        repeat (lat) tick();
        mc_rdata = rdata;
        mc_done  = 1'b1;
        tick();
        mc_done  = 1'b0;
        mc_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        #1 rst_in = 1'b1;
        if_req = 1'b1;
        #1;
        checks++;
        if ({if_done, if_data, ld_done, ld_data, st_done, mc_valid, mc_we, mc_addr, mc_size, mc_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b addr=%h ld_data=%h, required all zero", mc_valid, mc_addr, ld_data);
        end
        tick(); tick();
        checks++;
        if (dut.starve_cnt !== 4'd0 || mc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got starve_cnt=%0d valid=%b, required 0 0", dut.starve_cnt, mc_valid);
        end
        if_req = 1'b0;
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_single_load();
        int w;
        ld_req = 1'b1; ld_addr = 32'h100; ld_size = 2'd0;
        push(LD, 32'h0000_00D4);
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size} !== {1'b0, 32'h100, 2'd0}) begin
            errors++;
            $display("FAIL load_issue: got wait=%0d we=%b addr=%h size=%0d, required 1 0 00000100 0", w, mc_we, mc_addr, mc_size);
        end
        tick();
        checks++;
        if (mc_valid !== 1'b0 || mc_addr !== 32'h100) begin
            errors++;
            $display("FAIL load_valid_pulse: got valid=%b addr=%h, required 0 00000100", mc_valid, mc_addr);
        end
        complete(32'hA1B2_C3D4, 3);
        checks++;
        if (ld_done !== 1'b1 || ld_data !== 32'h0000_00D4) begin
            errors++;
            $display("FAIL load_byte_done: got done=%b data=%h, required 1 000000d4", ld_done, ld_data);
        end
        ld_req = 1'b0;
        tick();
        ld_req = 1'b1; ld_addr = 32'h104; ld_size = 2'd1;
        push(LD, 32'h0000_C3D4);
        wait_issue(w);
        complete(32'hA1B2_C3D4, 2);
        ld_req = 1'b0;
        checks++;
        if (ld_data !== 32'h0000_C3D4) begin
            errors++;
            $display("FAIL load_half_data: got %h, required 0000c3d4", ld_data);
        end
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_load_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_contention();
        int w;
        if_addr = 32'h200; ld_addr = 32'h300; ld_size = 2'd2;
        st_addr = 32'h400; st_size = 2'd2; st_data = 32'h1122_3344;
        push(ST, 32'h0); push(LD, 32'h5566_7788); push(FE, 32'h99AA_BBCC);
        if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size, mc_wdata} !== {1'b1, 32'h400, 2'd2, 32'h1122_3344}) begin
            errors++;
            $display("FAIL contention_store: got wait=%0d we=%b addr=%h wdata=%h, required 1 1 00000400 11223344", w, mc_we, mc_addr, mc_wdata);
        end
        complete(32'h0, 1);
        st_req = 1'b0;
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size} !== {1'b0, 32'h300, 2'd2}) begin
            errors++;
            $display("FAIL contention_load: got wait=%0d we=%b addr=%h, required 1 0 00000300", w, mc_we, mc_addr);
        end
        complete(32'h5566_7788, 1);
        ld_req = 1'b0;
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size} !== {1'b0, 32'h200, 2'd2}) begin
            errors++;
            $display("FAIL contention_fetch: got wait=%0d we=%b addr=%h size=%0d, required 1 0 00000200 2", w, mc_we, mc_addr, mc_size);
        end
        complete(32'h99AA_BBCC, 1);
        if_req = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0 || if_data !== 32'h99AA_BBCC) begin
            errors++;
            $display("FAIL contention_drain: got pending=%0d if_data=%h, required 0 99aabbcc", sb.size(), if_data);
        end
    endtask

    task automatic test_starvation();
        int w;
        if_addr = 32'h500; st_addr = 32'h600; st_size = 2'd2; st_data = 32'h1;
        ld_addr = 32'h700; ld_size = 2'd2;
        push(ST, 32'h0); push(LD, 32'hAAAA_0001); push(ST, 32'h0);
        if_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
        wait_issue(w);
        complete(32'h0, 1);
        st_req = 1'b0;
        wait_issue(w);
        checks++;
        if (w != 1 || mc_addr !== 32'h700) begin
            errors++;
            $display("FAIL starve_load: got wait=%0d addr=%h, required 1 00000700", w, mc_addr);
        end
        complete(32'hAAAA_0001, 1);
        ld_req = 1'b0; st_req = 1'b1; st_data = 32'h2;
        wait_issue(w);
        checks++;
        if (w != 1 || mc_addr !== 32'h600 || mc_we !== 1'b1) begin
            errors++;
            $display("FAIL starve_store2: got wait=%0d addr=%h we=%b, required 1 00000600 1", w, mc_addr, mc_we);
        end
        complete(32'h0, 1);
        checks++;
        if (dut.starve_cnt !== 4'd9) begin
            errors++;
            $display("FAIL starve_count: got %0d, required 9", dut.starve_cnt);
        end
        ld_req = 1'b1; ld_addr = 32'h704;
        push(FE, 32'h1234_5678); push(ST, 32'h0); push(LD, 32'hAAAA_0002);
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size} !== {1'b0, 32'h500, 2'd2} || dut.starve_cnt !== 4'd0) begin
            errors++;
            $display("FAIL starve_fetch_grant: got wait=%0d we=%b addr=%h cnt=%0d, required 1 0 00000500 0", w, mc_we, mc_addr, dut.starve_cnt);
        end
        complete(32'h1234_5678, 1);
        if_req = 1'b0;
        wait_issue(w);
        complete(32'h0, 1);
        st_req = 1'b0;
        wait_issue(w);
        complete(32'hAAAA_0002, 1);
        ld_req = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL starve_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        int w;
        ld_req = 1'b1; ld_addr = 32'h800; ld_size = 2'd2;
        wait_issue(w);
        tick();
        flush_in = 1'b1; ld_req = 1'b0;
        tick();
        flush_in = 1'b0;
        tick();
        complete(32'h5555_5555, 0);
        checks++;
        if (ld_done !== 1'b0 || ld_data !== 32'hAAAA_0002) begin
            errors++;
            $display("FAIL flush_suppress: got done=%b data=%h, required 0 aaaa0002", ld_done, ld_data);
        end
        tick();
        // Flush in IDLE blocks the load but not the committed store.
        st_req = 1'b1; st_addr = 32'h900; st_size = 2'd1; st_data = 32'hBEEF;
        ld_req = 1'b1; ld_addr = 32'h904; ld_size = 2'd2; flush_in = 1'b1;
        push(ST, 32'h0); push(LD, 32'h0BAD_F00D);
        tick();
        flush_in = 1'b0;
        checks++;
        if (mc_valid !== 1'b1 || {mc_we, mc_addr, mc_size} !== {1'b1, 32'h900, 2'd1}) begin
            errors++;
            $display("FAIL flush_store_grant: got valid=%b we=%b addr=%h, required 1 1 00000900", mc_valid, mc_we, mc_addr);
        end
        complete(32'h0, 1);
        st_req = 1'b0;
        wait_issue(w);
        complete(32'h0BAD_F00D, 1);
        ld_req = 1'b0;
        // Flush and mc_done together: done suppressed, straight back to IDLE.
        ld_req = 1'b1; ld_addr = 32'hA00;
        wait_issue(w);
        tick();
        flush_in = 1'b1; mc_done = 1'b1; mc_rdata = 32'h7777_7777; ld_req = 1'b0;
        tick();
        flush_in = 1'b0; mc_done = 1'b0;
        checks++;
        if (ld_done !== 1'b0 || ld_data !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL flush_same_cycle: got done=%b data=%h, required 0 0badf00d", ld_done, ld_data);
        end
        ld_req = 1'b1; ld_addr = 32'hA04;
        push(LD, 32'h0000_0042);
        wait_issue(w);
        checks++;
        if (w != 1 || mc_addr !== 32'hA04) begin
            errors++;
            $display("FAIL flush_recover: got wait=%0d addr=%h, required 1 00000a04", w, mc_addr);
        end
        complete(32'h0000_0042, 1);
        ld_req = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flush_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_io_backpressure();
        int w, bad;
        io_buffer_full = 1'b1;
        st_req = 1'b1; st_addr = 32'h30000; st_size = 2'd0; st_data = 32'h41;
        ld_req = 1'b1; ld_addr = 32'hB00; ld_size = 2'd1;
        push(LD, 32'h0000_BEEF); push(ST, 32'h0);
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr} !== {1'b0, 32'hB00}) begin
            errors++;
            $display("FAIL io_load_first: got wait=%0d we=%b addr=%h, required 1 0 00000b00", w, mc_we, mc_addr);
        end
        complete(32'h1234_BEEF, 1);
        ld_req = 1'b0;
        bad = 0;
        repeat (6) begin
            tick();
            if (mc_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL io_blocked: got %0d issue cycles while full, required 0", bad);
        end
        io_buffer_full = 1'b0;
        wait_issue(w);
        checks++;
        if (w != 1 || {mc_we, mc_addr, mc_size, mc_wdata} !== {1'b1, 32'h30000, 2'd0, 32'h41}) begin
            errors++;
            $display("FAIL io_store_issue: got wait=%0d we=%b addr=%h wdata=%h, required 1 1 00030000 00000041", w, mc_we, mc_addr, mc_wdata);
        end
        complete(32'h0, 1);
        st_req = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL io_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_rdy_and_reset();
        int w, bad;
        ld_req = 1'b1; ld_addr = 32'hC00; ld_size = 2'd2;
        push(LD, 32'hCAFE_F00D);
        wait_issue(w);
        tick();
        rdy_in = 1'b0;
        tick();
        mc_done = 1'b1; mc_rdata = 32'hCAFE_F00D;
        bad = 0;
        repeat (3) begin
            tick();
            if (ld_done !== 1'b0 || mc_addr !== 32'hC00 || mc_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rdy_freeze: got %0d cycles with state change, required 0", bad);
        end
        rdy_in = 1'b1;
        tick();
        mc_done = 1'b0;
        checks++;
        if (ld_done !== 1'b1 || ld_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rdy_resume: got done=%b data=%h, required 1 cafef00d", ld_done, ld_data);
        end
        ld_req = 1'b0;
        tick();
        // Async reset while a load waits on the controller.
        ld_req = 1'b1; ld_addr = 32'hD00;
        wait_issue(w);
        tick();
        rst_in = 1'b1;
        #1;
        checks++;
        if ({if_done, if_data, ld_done, ld_data, st_done, mc_valid, mc_we, mc_addr, mc_size, mc_wdata} !== '0) begin
            errors++;
            $display("FAIL async_reset: got addr=%h ld_data=%h if_data=%h, required all zero", mc_addr, ld_data, if_data);
        end
        ld_req = 1'b0;
        tick();
        rst_in = 1'b0;
        complete(32'h9999_9999, 0);
        tick();
        checks++;
        if (ld_done !== 1'b0 || ld_data !== 32'h0 || mc_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_done: got done=%b data=%h valid=%b, required 0 0 0", ld_done, ld_data, mc_valid);
        end
        ld_req = 1'b1; ld_addr = 32'hD04; ld_size = 2'd0;
        push(LD, 32'h0000_0077);
        wait_issue(w);
        checks++;
        if (w != 1 || mc_addr !== 32'hD04) begin
            errors++;
            $display("FAIL post_reset_issue: got wait=%0d addr=%h, required 1 00000d04", w, mc_addr);
        end
        complete(32'h1122_3377, 1);
        ld_req = 1'b0;
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_starvation();
        test_flush();
        test_io_backpressure();
        test_rdy_and_reset();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
